// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selectors and
// the set of supported oversampling ratios.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Oversampling ratios the sampler's mid-bit window is sized for.
    function automatic bit prescale_legal(input int p);
        return (p == 8) || (p == 16) || (p == 32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling: edge counter, three mid-bit samples and a
// 2-of-3 majority vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,          // count this cycle; low forces the counter to 0
    input  logic din,          // synchronized serial line
    output logic sampled_bit,  // majority value, valid once sample_done
    output logic sample_done,  // all three samples captured
    output logic bit_end       // last clk of the current bit
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] S_LO   = CW'(PRESCALE/2 - 1);
    localparam logic [CW-1:0] S_MID  = CW'(PRESCALE/2);
    localparam logic [CW-1:0] S_HI   = CW'(PRESCALE/2 + 1);
    localparam logic [CW-1:0] S_DONE = CW'(PRESCALE/2 + 2);
    localparam logic [CW-1:0] S_LAST = CW'(PRESCALE - 1);

    if (!prescale_legal(PRESCALE)) begin : g_bad_prescale
        $error("uart_rx_sampler: PRESCALE must be 8, 16 or 32");
    end

    logic [CW-1:0] edge_cnt;
    logic [2:0]    smp;

    // Position within the current bit; held at 0 while not running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   edge_cnt <= '0;
        else if (!run)             edge_cnt <= '0;
        else if (edge_cnt == S_LAST) edge_cnt <= '0;
        else                       edge_cnt <= edge_cnt + 1'b1;
    end

    // Capture the line at three points around the bit centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp <= '0;
        end else if (run) begin
            if (edge_cnt == S_LO)  smp[0] <= din;
            if (edge_cnt == S_MID) smp[1] <= din;
            if (edge_cnt == S_HI)  smp[2] <= din;
        end
    end

    assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign sample_done = (edge_cnt == S_DONE);
    assign bit_end     = (edge_cnt == S_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the line, frames start/data/parity/stop and
// reports each frame as exactly one of valid word, parity error or stop error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int PRESCALE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_data_rx,
    input  logic              parity_en_rx,
    input  logic              parity_type_rx,
    output logic [DWIDTH-1:0] p_data_rx,
    output logic              data_valid_rx,
    output logic              parity_err_rx,
    output logic              stop_err_rx,
    output logic              busy_rx
);

    localparam int BCW = $clog2(DWIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DWIDTH - 1);

    rx_state_e         state;
    logic [1:0]        sync_q;
    logic              s_sync;
    logic              s_prev;
    logic              start_det;
    logic [BCW-1:0]    bit_cnt;
    logic [DWIDTH-1:0] shift_q;
    logic              par_en_q;
    logic              par_type_q;
    logic              par_flag;
    logic              run;
    logic              abort;
    logic              sampled_bit;
    logic              sample_done;
    logic              bit_end;

    // Two-flop synchronizer plus previous-value flop for edge detection;
    // all reset high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            s_prev <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], s_data_rx};
            s_prev <= s_sync;
        end
    end

    assign s_sync    = sync_q[1];
    assign start_det = s_prev & ~s_sync;

    // A start glitch must clear the edge counter so an immediately
    // following falling edge still begins at edge_cnt = 0.
    assign abort = (state == START) && sample_done && sampled_bit;
    assign run   = (state == IDLE) ? start_det : !abort;

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .din         (s_sync),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .bit_end     (bit_end)
    );

    // Frame FSM with registered result pulses and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_q       <= '0;
            par_en_q      <= 1'b0;
            par_type_q    <= PARITY_EVEN;
            par_flag      <= 1'b0;
            p_data_rx     <= '0;
            data_valid_rx <= 1'b0;
            parity_err_rx <= 1'b0;
            stop_err_rx   <= 1'b0;
            busy_rx       <= 1'b0;
        end else begin
            data_valid_rx <= 1'b0;
            parity_err_rx <= 1'b0;
            stop_err_rx   <= 1'b0;
            case (state)
                IDLE: begin
                    // busy stays up through the result-pulse cycle and
                    // continues seamlessly into a back-to-back frame.
                    busy_rx  <= start_det;
                    bit_cnt  <= '0;
                    par_flag <= 1'b0;
                    if (start_det) begin
                        state      <= START;
                        par_en_q   <= parity_en_rx;
                        par_type_q <= parity_type_rx;
                    end
                end
                START: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy_rx <= 1'b0;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= {sampled_bit, shift_q[DWIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_flag <= (sampled_bit != ((^shift_q) ^ par_type_q));
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!sampled_bit) begin
                            stop_err_rx <= 1'b1;
                        end else if (par_flag) begin
                            parity_err_rx <= 1'b1;
                        end else begin
                            p_data_rx     <= shift_q;
                            data_valid_rx <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic
// checked against a frame-level reference model.
module tb_uart_rx;

    localparam int DW = 8;
    localparam int P  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_data_rx = 1'b1;
    logic          parity_en_rx = 1'b0;
    logic          parity_type_rx = 1'b0;
    logic [DW-1:0] p_data_rx;
    logic          data_valid_rx;
    logic          parity_err_rx;
    logic          stop_err_rx;
    logic          busy_rx;

    always #5 clk = ~clk;

    uart_rx #(.DWIDTH(DW), .PRESCALE(P)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_data_rx      (s_data_rx),
        .parity_en_rx   (parity_en_rx),
        .parity_type_rx (parity_type_rx),
        .p_data_rx      (p_data_rx),
        .data_valid_rx  (data_valid_rx),
        .parity_err_rx  (parity_err_rx),
        .stop_err_rx    (stop_err_rx),
        .busy_rx        (busy_rx)
    );

    // kind: 1 valid, 2 parity error, 3 stop error, 4 several pulses at once
    typedef struct {
        int          cyc;
        int          kind;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           obs_q[$];
    ev_t           exp_q[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] last_good = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every result pulse with its cycle and the word on p_data_rx.
    always @(negedge clk) begin
        int  k;
        ev_t e;
        k = int'(data_valid_rx) + int'(parity_err_rx) + int'(stop_err_rx);
        if (k != 0) begin
            e.cyc  = cyc;
            e.kind = (k > 1) ? 4 : data_valid_rx ? 1 : parity_err_rx ? 2 : 3;
            e.data = p_data_rx;
            obs_q.push_back(e);
        end
    end

    task automatic line_bits(input logic b, input int n);
        s_data_rx = b;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame and queue the outcome the frame rules predict.
    task automatic send_frame(input logic [DW-1:0] d, input bit pen, input bit pty,
                              input bit bad_par, input bit bad_stop, input bit scramble);
        int   n0;
        int   nbits;
        logic pbit;
        ev_t  e;
        n0 = cyc;
        parity_en_rx   = pen;
        parity_type_rx = pty;
        line_bits(1'b0, P);
        if (scramble) begin
            parity_en_rx   = 1'($urandom_range(0, 1));
            parity_type_rx = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < DW; i++) line_bits(d[i], P);
        // Correct parity makes the count of ones (data + parity) even for
        // even parity and odd for odd parity.
        pbit = 1'(($countones(d) + (pty ? 1 : 0)) % 2) ^ bad_par;
        if (pen) line_bits(pbit, P);
        line_bits(!bad_stop, P);
        nbits  = 2 + DW + (pen ? 1 : 0);
        e.cyc  = n0 + 2 + nbits * P;
        if (bad_stop) begin
            e.kind = 3; e.data = last_good;
        end else if (pen && bad_par) begin
            e.kind = 2; e.data = last_good;
        end else begin
            e.kind = 1; e.data = d; last_good = d;
        end
        exp_q.push_back(e);
    endtask

    task automatic settle_and_compare(input string tag);
        ev_t o;
        ev_t x;
        repeat (2 * P) @(negedge clk);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            chk({tag, "_cyc"},  o.cyc,  x.cyc);
            chk({tag, "_kind"}, o.kind, x.kind);
            chk({tag, "_data"}, o.data, x.data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  bc;
        bit  prev_bad_stop;
        int  gap;
        bit  pen, bps, bpp;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {p_data_rx, data_valid_rx, parity_err_rx, stop_err_rx, busy_rx}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Even-parity 0xA5.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle_and_compare("a5_even");
        chk("a5_word", p_data_rx, 8'hA5);

        // Odd parity selected, wrong parity bit sent.
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        settle_and_compare("3c_parerr");
        chk("3c_word_kept", p_data_rx, 8'hA5);

        // Stop bit 0, then line held low: no new frame until it rises.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        line_bits(1'b0, 5 * P);
        settle_and_compare("55_break");
        line_bits(1'b1, P);
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle_and_compare("after_break");

        // Two-cycle low glitch while idle.
        line_bits(1'b1, P);
        line_bits(1'b0, 2);
        s_data_rx = 1'b1;
        bc = 0;
        repeat (3 * P) begin
            @(negedge clk);
            if (busy_rx) bc++;
        end
        chk("glitch_busy_seen", bc > 0, 1);
        chk("glitch_busy_bound", bc <= P / 2 + 3, 1);
        chk("glitch_busy_end", busy_rx, 0);
        settle_and_compare("glitch");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_busy", busy_rx, 1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle_and_compare("b2b");

        // Reset during data bit 4.
        line_bits(1'b1, P);
        parity_en_rx = 1'b0;
        line_bits(1'b0, P);
        for (int i = 0; i < 4; i++) line_bits(1'(i % 2), P);
        repeat (P / 2) @(negedge clk);
        chk("midframe_busy", busy_rx, 1);
        rst = 1'b1;
        #1;
        chk("midframe_reset_outputs",
            {p_data_rx, data_valid_rx, parity_err_rx, stop_err_rx, busy_rx}, 0);
        s_data_rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = '0;
        line_bits(1'b1, 2 * P);
        chk("after_reset_busy", busy_rx, 0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle_and_compare("reset_then_81");

        // Randomized traffic: data, parity mode, error injection, gaps,
        // and parity inputs changed mid-frame.
        prev_bad_stop = 1'b0;
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 20);
            if (prev_bad_stop && gap == 0) gap = 1;
            if (gap > 0) line_bits(1'b1, gap);
            pen = 1'($urandom_range(0, 1));
            bpp = ($urandom_range(0, 4) == 0);
            bps = ($urandom_range(0, 5) == 0);
            send_frame(DW'($urandom), pen, 1'($urandom_range(0, 1)), bpp, bps, 1'b1);
            prev_bad_stop = bps;
        end
        line_bits(1'b1, P);
        settle_and_compare("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver.
- Counterpart of the team's uart_tx transmitter; its serial input connects to the transmitter's s_data_tx line.
- Oversamples the line at PRESCALE× the bit rate, majority-votes each bit and reassembles the frame: start, DWIDTH data bits LSB-first, optional parity, one stop bit.
- Outputs the parallel word with a one-cycle valid pulse, or a one-cycle error pulse.

Parameters:
- DWIDTH, 8, data bits per frame.
- PRESCALE, 8, clk cycles per bit. Legal values: 8, 16, 32.

Ports:
- clk  input  1  receiver clock; frequency = PRESCALE × bit rate.
- rst  input  1  asynchronous, active-high reset.
- s_data_rx  input  1  serial line; idle high; asynchronous to clk.
- parity_en_rx  input  1  1 = a parity bit follows the data bits.
- parity_type_rx  input  1  0 = even, 1 = odd.
- p_data_rx  output  DWIDTH  last correctly received word.
- data_valid_rx  output  1  one-cycle pulse: p_data_rx updated.
- parity_err_rx  output  1  one-cycle pulse: parity mismatch on the completed frame.
- stop_err_rx  output  1  one-cycle pulse: stop bit sampled 0.
- busy_rx  output  1  high while a frame is being received (any state except IDLE).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All counters and the shift register = 0.
  - p_data_rx = 0; data_valid_rx, parity_err_rx, stop_err_rx, busy_rx = 0.
  - Synchronizer flops = 1 (idle line).
- Synchronization:
  - s_data_rx passes through a 2-flop synchronizer; the output is s_sync.
  - All decisions use s_sync.
  - A falling edge is detected when the previous s_sync = 1 and the current s_sync = 0.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 within each bit and wraps to 0.
  - bit_cnt counts bits within the DATA state.
- Bit sampling:
  - s_sync is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the 2-of-3 majority, valid from edge_cnt = PRESCALE/2+2.
- States (all transitions occur when edge_cnt = PRESCALE-1, except where noted):
  - IDLE: on a falling edge of s_sync, go to START. That cycle is T0, with edge_cnt = 0. parity_en_rx and parity_type_rx are latched at T0 and hold for the whole frame; mid-frame changes are ignored.
  - START: if the majority value = 1, treat it as a glitch and return to IDLE at edge_cnt = PRESCALE/2+2, with no output pulse. Otherwise go to DATA.
  - DATA: each sampled bit is shifted in LSB-first. After DWIDTH bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: compute the expected bit = XOR(data) XOR parity_type. A mismatch sets an internal flag.
  - STOP: at edge_cnt = PRESCALE-1, exactly one outcome is registered:
    - stop bit = 0 → stop_err_rx pulses. stop_err_rx takes priority over parity_err_rx.
    - else parity flag set → parity_err_rx pulses.
    - else → p_data_rx <= shift register, and data_valid_rx pulses.
  - State then returns to IDLE.
- Latency: outputs are registered, so the pulse is high in cycle T0 + FRAME×PRESCALE, where FRAME = 2 + DWIDTH + parity_en. Each pulse is high for exactly one clk.
- On an error, p_data_rx keeps its previous value.
- Back-to-back frames: a falling edge in the first IDLE cycle after STOP starts the next frame. No idle bit is required beyond the stop bit.
- Break handling: a line held low after a stop_err_rx does not start a new frame until s_sync has been 1 for at least one cycle (falling-edge detect).
- busy_rx is high from T0+1 until the cycle of the output pulse, inclusive.
- Reset mid-frame: immediate abort, all outputs return to reset values, and no pulse is produced.
- The pulse outputs are mutually exclusive. At most one output pulse occurs per frame.

Decomposition:
- Shared package uart_pkg holds:
  - enum rx_state_e {IDLE, START, DATA, PARITY, STOP};
  - PARITY_EVEN = 1'b0 and PARITY_ODD = 1'b1, shared with the TX side.
  - The legal PRESCALE values, checked by a static assertion.
- One sub-module, uart_rx_sampler:
  - Contains the edge counter, the three-sample capture and the majority vote.
  - Outputs sampled_bit, sample_done and bit_end.
  - Top level contains the FSM, bit counter, shift register, parity check and output registers.

Test Plan (DWIDTH=8, PRESCALE=8, line driven at 1 bit per 8 clk):
- Frame 0xA5 with even parity (bits 1,0,1,0,0,1,0,1, parity 0, stop 1) → p_data_rx = 0xA5; data_valid_rx high exactly 1 cycle at T0+88; no errors.
- Frame 0x3C, odd parity selected, but the parity bit is sent as 0 (correct value is 1) → parity_err_rx pulse at T0+88; data_valid_rx stays 0; p_data_rx keeps 0xA5.
- Frame 0x55, no parity, stop bit driven 0 → stop_err_rx pulse at T0+80. With the line held low afterwards, no new frame starts until the line returns high and falls again.
- Line pulsed low for 2 clk while idle → no output pulse; busy_rx returns to 0 within PRESCALE/2+3 cycles.
- Back-to-back frames 0x00 then 0xFF, no parity, no idle gap → two data_valid_rx pulses exactly 80 cycles apart, with p_data_rx = 0x00 then 0xFF.
- rst asserted during data bit 4 of a frame → outputs immediately 0; no pulse. The following clean 0x81 frame is received correctly.
